// File: rtl/display_pkg.sv
// display_pkg: shared types and segment encodings for the 16-segment display driver
package display_pkg;
    typedef logic [15:0] seg_t;
    localparam seg_t SEG_CODE [0:9] = '{
        16'h7F86, 16'h3000, 16'h6EE0, 16'h7CE0, 16'h3160,
        16'h5DE0, 16'h5FE0, 16'h7100, 16'h7FE0, 16'h7DE0
    };
    localparam seg_t SEG_BLANK = 16'h0000;
    localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/display_mux_seg16_decode.sv
// seg16_decode: maps one BCD nibble to its 16-segment pattern, blank and flagged when above 9
module seg16_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       code,
    output logic       invalid
);
    // non-decimal nibbles render blank rather than garbage
    always_comb begin
        invalid = bcd > BCD_MAX;
        code    = invalid ? SEG_BLANK : SEG_CODE[bcd];
    end
endmodule

// File: rtl/display_mux.sv
// display_mux: multiplexed multi-digit 16-segment driver with blink and optional leading-zero blanking (DISPLAY_MUX_LZB_EN)
module display_mux
    import display_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [DIGITS-1:0]   blink_mask,
    output seg_t                seg,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                bcd_err
);
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]            presc;
    logic [IW-1:0]            idx;
    logic [BW-1:0]            bcnt;
    logic                     phase;
    logic [DIGITS-1:0][3:0]   shadow;
    logic [DIGITS-1:0]        lz;
    logic                     tick;
    logic                     err_in;
    logic                     invalid;
    seg_t                     code;

    assign tick = presc == P_LAST;

    seg16_decode u_dec (
        .bcd     (shadow[idx]),
        .code    (code),
        .invalid (invalid)
    );

`ifdef DISPLAY_MUX_LZB_EN
    logic run;
`endif
    // leading-zero mask: a digit is blank when it and all higher digits are zero; digit 0 always shows
    always_comb begin
        lz = '0;
`ifdef DISPLAY_MUX_LZB_EN
        run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run   = run && shadow[i] == 4'd0;
            lz[i] = run;
        end
`endif
    end

    // flag any non-decimal nibble in the incoming value
    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) err_in = err_in | (bcd_in[4*i +: 4] > BCD_MAX);
    end

    // prescaler, digit index and frame-based blink phase; these run regardless of enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= idx == I_LAST ? '0 : idx + 1'b1;
                if (idx == I_LAST) begin
                    bcnt <= bcnt == B_LAST ? '0 : bcnt + 1'b1;
                    if (bcnt == B_LAST) phase <= ~phase;
                end
            end
        end
    end

    // shadow copy and its validity flag, captured together on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            bcd_err <= 1'b0;
        end else if (load) begin
            shadow  <= bcd_in;
            bcd_err <= err_in;
        end
    end

    // output registers updated once per slot with the blanking priority applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= SEG_BLANK;
            digit_sel <= '0;
        end else if (tick) begin
            digit_sel <= enable ? DIGITS'(1) << idx : '0;
            seg       <= (!enable || (phase && blink_mask[idx]) || lz[idx] || invalid) ? SEG_BLANK : code;
        end
    end
endmodule

// File: doc/display_mux.md
# display_mux

Parametrised multi-digit driver for the 16-segment display on the coffee machine front panel. It holds a shadow copy of a packed BCD value, time-multiplexes the digits with a programmable refresh prescaler, and drives one registered segment bus plus a one-hot digit select. It adds per-digit blinking and invalid-code flagging, and optionally blanks leading zeros. It sits between the machine controller (price, credit and countdown values) and the panel pins.

## Interface
- DIGITS, 4: number of digits; must be at least 1.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be at least 1.
- BLINK_FRAMES, 64: number of complete scan frames per blink half-period; must be at least 1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  display on. Low blanks the outputs; the counters keep running.
- load  in  1  single-cycle strobe that captures bcd_in into the shadow register.
- bcd_in  in  4*DIGITS  packed BCD. Bits [3:0] are digit 0, the least significant digit.
- blink_mask  in  DIGITS  digit i blinks while bit i is 1. Sampled live.
- seg  out  16  registered segment pattern for the digit currently selected.
- digit_sel  out  DIGITS  registered one-hot digit select, active high.
- bcd_err  out  1  registered; high while any shadow nibble is greater than 9.

## Operation
- The shadow register is loaded on any edge where load=1.
- bcd_err is updated on the same edge as the shadow load, from bcd_in.
- Segment codes:
  - 0=0x7F86, 1=0x3000, 2=0x6EE0, 3=0x7CE0, 4=0x3160
  - 5=0x5DE0, 6=0x5FE0, 7=0x7100, 8=0x7FE0, 9=0x7DE0
  - nibble 10–15: 0x0000 (blank)
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler == REFRESH_DIV-1).
- Digit index idx counts 0..DIGITS-1. On each tick:
  - seg <= code(shadow[idx]), subject to the blanking rules below.
  - digit_sel <= onehot(idx).
  - idx advances, wrapping from DIGITS-1 to 0.
- Frame: one full idx wrap. The blink counter counts completed frames. blink_phase toggles every BLINK_FRAMES frames.
- Blanking priority on a tick, highest first:
  1. enable=0: seg=0 and digit_sel=0.
  2. blink_phase=1 and blink_mask[idx]=1: seg=0, digit_sel still driven.
  3. Leading-zero blanking (see Configuration): seg=0, digit_sel still driven.
  4. Otherwise the decoded code.
- Widths:
  - prescaler: max($clog2(REFRESH_DIV),1) bits.
  - idx: max($clog2(DIGITS),1) bits.
  - blink counter: max($clog2(BLINK_FRAMES),1) bits.
  - No counter ever exceeds its terminal value.

## Timing
- Reset values: seg=0, digit_sel=0, bcd_err=0, shadow=0, prescaler=0, idx=0, blink counter=0, blink_phase=0.
- After rst is released, the first tick is on cycle REFRESH_DIV. Outputs change on the edge following that tick; that first update shows digit 0.
- load and tick on the same edge: the tick uses the old shadow. The new value first appears at the next tick.
- Load latency to display: up to DIGITS*REFRESH_DIV cycles. bcd_err responds one cycle after load.
- REFRESH_DIV=1: a tick occurs every cycle, so digits rotate each clock.
- DIGITS=1: digit_sel stays at 1 while enabled, and every tick completes a frame.
- The enable level is sampled only on ticks. Re-enabling resumes at the current idx; the scan does not restart.
- Asserting rst mid-scan clears all outputs asynchronously, with no clock edge needed.

## Configuration
- DISPLAY_MUX_LZB_EN defined:
  - Digit i (i>0) is blanked when shadow[i] and every higher shadow digit equal 0.
  - Digit 0 is never blanked.
  - Blanked digits keep digit_sel driven.
- Not defined: all digits are displayed, and zeros show 0x7F86.

## Structure
- Package display_pkg:
  - seg_t (logic [15:0]).
  - SEG_CODE[0:9] constant array.
  - SEG_BLANK = 16'h0000.
  - BCD_MAX = 9.
- Sub-module seg16_decode: combinational. Input 4-bit bcd; outputs seg_t code and an invalid flag. One instance is shared, indexed by idx.
- display_mux holds the prescaler, index counter, blink counter, shadow register, leading-zero mask and output registers.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, and enable=1 unless stated.
- Reset, then load bcd_in=0x1234 → successive ticks give:
  - digit_sel 0001/seg 0x3160
  - digit_sel 0010/seg 0x7CE0
  - digit_sel 0100/seg 0x6EE0
  - digit_sel 1000/seg 0x3000
  - then wrap back to digit 0.
- Load 0x0070:
  - With DISPLAY_MUX_LZB_EN: digits 3 and 2 give seg 0x0000, digit 1 gives 0x7100, digit 0 gives 0x7F86.
  - Without the macro: digits 3 and 2 give 0x7F86.
- Load 0x00A5 → bcd_err=1 one cycle later; digit 1 gives seg 0x0000; digit 0 gives 0x5DE0. Reload 0x0005 → bcd_err returns to 0.
- blink_mask=0001 with 0x1234 loaded → digit 0 shows 0x3160 in frames 0–1, 0x0000 in frames 2–3, and the pattern repeats. Other digits are unaffected.
- enable driven to 0 mid-frame → from the next tick, seg=0 and digit_sel=0. Re-enable → scanning continues at the digit following the last idx.
- Assert rst between two clock edges during a scan → seg, digit_sel and bcd_err go to 0 immediately. After release, the first tick is at cycle 4 and shows digit 0 with seg 0x7F86.
